fp_fma_arbiter: RTL

//  Shares one pipelined fp_fma_wrapper between NUM_REQ requesters (cores/APU ports).

---
 rtl/fp_fma_arb_pkg.sv | 25 ++
 rtl/fp_rr_arbiter.sv | 37 +++
 rtl/fp_fma_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fp_fma_arb_pkg.sv
// rtl/fp_fma_arb_pkg.sv - shared types and constants for the FMA arbiter slice
//
// Purpose : op-code encodings of the FMA wrapper, default pipeline depth and
//           the tag carried alongside each issued op.
// Contents: FMA_OP_* codes, FMA_LATENCY_DEFAULT, TAG_ID_W, tag_t.
package fp_fma_arb_pkg;

  // bit0 negates the addend, bit1 negates the product
  localparam logic [1:0] FMA_OP_MADD  = 2'b00;
  localparam logic [1:0] FMA_OP_MSUB  = 2'b01;
  localparam logic [1:0] FMA_OP_NMSUB = 2'b10;
  localparam logic [1:0] FMA_OP_NMADD = 2'b11;

  localparam int unsigned FMA_LATENCY_DEFAULT = 2;

  // Fixed-width id field so the tag type can live in the package; it holds
  // requester indices for up to 2**TAG_ID_W requesters.
  localparam int unsigned TAG_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// rtl/fp_rr_arbiter.sv - combinational round-robin pick from a request vector
//
// Purpose : first asserted request at or after ptr_i, wrapping around.
// Ports   : req_i   request vector
//           ptr_i   highest-priority index this cycle
//           gnt_o   one-hot grant
//           idx_o   binary index of the grant
//           valid_o any grant issued
module fp_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               valid_o
);

  int unsigned k;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/fp_fma_arbiter.sv
// rtl/fp_fma_arbiter.sv - shares one pipelined FMA between several requesters
//
// Purpose : round-robin issue of one op per cycle with a per-requester cap on
//           in-flight ops; a tag pipeline matched to the FMA latency routes
//           each result back to its owner.
// Ports   : clk_i, rst_ni                     clock, async active-low reset
//           req_i/opa_i/opb_i/opc_i/op_i/rnd_i requester-side op, packed per requester
//           gnt_o                              one-hot accept
//           rvalid_o/res_o/status_o            one-hot result strobe + result
//           fma_en_o/fma_op*_o/fma_rnd_o       issue side of the FMA
//           fma_valid_i/fma_res_i/fma_status_i return side of the FMA
//           err_o                              sticky FMA/tag disagreement
module fp_fma_arbiter
  import fp_fma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned FMA_LATENCY = FMA_LATENCY_DEFAULT,
  parameter int unsigned MAX_OUTST   = 2,
  parameter int unsigned RND_WIDTH   = 2,
  parameter int unsigned STAT_WIDTH  = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*32-1:0]        opa_i,
  input  logic [NUM_REQ*32-1:0]        opb_i,
  input  logic [NUM_REQ*32-1:0]        opc_i,
  input  logic [NUM_REQ*2-1:0]         op_i,
  input  logic [NUM_REQ*RND_WIDTH-1:0] rnd_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           rvalid_o,
  output logic [31:0]                  res_o,
  output logic [STAT_WIDTH-1:0]        status_o,
  output logic                         fma_en_o,
  output logic [31:0]                  fma_opa_o,
  output logic [31:0]                  fma_opb_o,
  output logic [31:0]                  fma_opc_o,
  output logic [1:0]                   fma_op_o,
  output logic [RND_WIDTH-1:0]         fma_rnd_o,
  input  logic                         fma_valid_i,
  input  logic [31:0]                  fma_res_i,
  input  logic [STAT_WIDTH-1:0]        fma_status_i,
  output logic                         err_o
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTST + 1);

  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     winner;
  logic               any_gnt;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] ret;
  logic [CW-1:0]      cnt_q [NUM_REQ];
  tag_t               tag_q [FMA_LATENCY];
  tag_t               tail;

  assign tail = tag_q[FMA_LATENCY-1];

  // A requester at its cap may still issue in the cycle one of its ops
  // returns, which keeps a single requester at full rate when the cap equals
  // the pipeline depth. Eligibility is masked in reset so nothing is granted.
  always_comb begin
    ret  = '0;
    elig = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      ret[r]  = tail.valid && (tail.id == TAG_ID_W'(r));
      elig[r] = rst_ni && req_i[r] && ((cnt_q[r] < CW'(MAX_OUTST)) || ret[r]);
    end
  end

  fp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_o),
    .idx_o   (winner),
    .valid_o (any_gnt)
  );

  assign fma_en_o = any_gnt;

  always_comb begin
    fma_opa_o = '0;
    fma_opb_o = '0;
    fma_opc_o = '0;
    fma_op_o  = '0;
    fma_rnd_o = '0;
    if (any_gnt) begin
      fma_opa_o = opa_i[32*int'(winner) +: 32];
      fma_opb_o = opb_i[32*int'(winner) +: 32];
      fma_opc_o = opc_i[32*int'(winner) +: 32];
      fma_op_o  = op_i[2*int'(winner) +: 2];
      fma_rnd_o = rnd_i[RND_WIDTH*int'(winner) +: RND_WIDTH];
    end
  end

  // Return routing trusts the tag pipeline, not fma_valid_i; a disagreement
  // only raises err_o.
  assign rvalid_o = ret;
  assign res_o    = fma_res_i;
  assign status_o = fma_status_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (any_gnt) begin
      ptr_q <= (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FMA_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: any_gnt, id: TAG_ID_W'(winner)};
      for (int i = 1; i < FMA_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REQ; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (gnt_o[r] && !ret[r]) begin
          assert (cnt_q[r] < CW'(MAX_OUTST));
          cnt_q[r] <= cnt_q[r] + 1'b1;
        end else if (ret[r] && !gnt_o[r]) begin
          assert (cnt_q[r] != '0);
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (fma_valid_i != tail.valid) begin
      err_o <= 1'b1;
    end
  end

endmodule
